// File: rtl/mips_pkg.sv
// Shared MIPS datapath package: register-file geometry, the zero register
// address and the common address/word types.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/mux_32.sv
// 2:1 32-bit select steering the write-back word onto a read port.
// Only present in builds with REGFILE_BYPASS_EN defined.
`ifdef REGFILE_BYPASS_EN
module mux_32
  import mips_pkg::*;
(
  input  logic  sel,
  input  word_t a,
  input  word_t b,
  output word_t y
);

  always_comb begin
    y = sel ? b : a;
  end

endmodule
`endif

// File: rtl/register_file.sv
// MIPS register file: 2^ADDR_W x DATA_W entries, two combinational read ports,
// one synchronous write port, entry 0 hardwired to zero, committed-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [15:0]       wr_count
);

  import mips_pkg::*;

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              commit;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd2_raw;

  // Writes aimed at register 0 are dropped and never counted.
  always_comb begin
    commit = regwrite && (wa != ZERO_ADDR);
  end

  always_comb begin
    mem_d      = mem_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      mem_d[wa]  = wd;
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Address 0 is forced to zero here so entry 0 never needs to be trusted.
  always_comb begin
    rd1_raw = (ra1 == ZERO_ADDR) ? '0 : mem_q[ra1];
    rd2_raw = (ra2 == ZERO_ADDR) ? '0 : mem_q[ra2];
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  always_comb begin
    byp1 = commit && (ra1 == wa);
    byp2 = commit && (ra2 == wa);
  end

  mux_32 u_byp1 (
    .sel (byp1),
    .a   (rd1_raw),
    .b   (wd),
    .y   (rd1)
  );

  mux_32 u_byp2 (
    .sel (byp2),
    .a   (rd2_raw),
    .b   (wd),
    .y   (rd2)
  );
`else
  assign rd1 = rd1_raw;
  assign rd2 = rd2_raw;
`endif

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// hazard/reset/wrap sequences and randomized traffic against an array model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        regwrite;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [32];
  int          ref_cnt = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  register_file dut (
    .clk      (clk),
    .rst      (rst),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] a,
                               input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    rst      = r;
    regwrite = we;
    wa       = a;
    wd       = d;
    ra1      = r1;
    ra2      = r2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge and apply the architectural write/reset rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      ref_cnt = 0;
    end else if (regwrite === 1'b1 && wa != 5'd0) begin
      ref_mem[wa] = wd;
      ref_cnt     = (ref_cnt + 1) % 65536;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
    if (regwrite === 1'b1 && wa != 5'd0 && ra == wa) return wd;
`endif
    if (ra == 5'd0) return 32'h0;
    return ref_mem[ra];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    vecs[0] = '{1'b0, 1'b1, 5'd10, 32'hDEADBEEF, 5'd0,  5'd1,  32'h0,        32'h0,        16'd0};
    vecs[1] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd10, 5'd0,  32'hDEADBEEF, 32'h0,        16'd1};
    vecs[2] = '{1'b0, 1'b1, 5'd3,  32'h12345678, 5'd0,  5'd10, 32'h0,        32'hDEADBEEF, 16'd1};
    vecs[3] = '{1'b0, 1'b0, 5'd10, 32'h0,        5'd3,  5'd10, 32'h12345678, 32'hDEADBEEF, 16'd2};
    vecs[4] = '{1'b0, 1'b1, 5'd10, 32'h00000001, 5'd3,  5'd3,  32'h12345678, 32'h12345678, 16'd2};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd10, 5'd0,  32'h00000001, 32'h0,        16'd3};
    vecs[6] = '{1'b1, 1'b1, 5'd3,  32'h0000AAAA, 5'd3,  5'd10, 32'h12345678, 32'h00000001, 16'd3};
    vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd10, 32'h0,        32'h0,        16'd0};

    // Reset, then sweep every address on both ports.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checkOutput("reset_rd1", rd1, 32'h0);
      checkOutput("reset_rd2", rd2, 32'h0);
    end
    checkOutput("reset_count", {16'h0, wr_count}, 32'h0);

    // Directed vectors: expectations are the pre-edge outputs of each cycle.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
      #2;
      checkOutput($sformatf("vec%0d_rd1", v), rd1, vecs[v].exp_rd1);
      checkOutput($sformatf("vec%0d_rd2", v), rd2, vecs[v].exp_rd2);
      checkOutput($sformatf("vec%0d_count", v), {16'h0, wr_count}, {16'h0, vecs[v].exp_cnt});
      step();
    end

    // Same-cycle write/read hazard on register 21.
    applyStimulus(1'b0, 1'b1, 5'd21, 32'h1, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd21, 32'h2, 5'd0, 5'd21);
    #2;
`ifdef REGFILE_BYPASS_EN
    checkOutput("hazard_pre_edge", rd2, 32'h2);
`else
    checkOutput("hazard_pre_edge", rd2, 32'h1);
`endif
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd21);
    #1;
    checkOutput("hazard_post_edge", rd2, 32'h2);

    // Unknown write enable must leave storage and counter untouched.
    applyStimulus(1'b0, 1'bx, 5'd21, 32'hBAD0BAD0, 5'd21, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd21, 5'd0);
    #1;
    checkOutput("x_we_data", rd1, 32'h2);
    checkOutput("x_we_count", {16'h0, wr_count}, 32'(ref_cnt));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        r, we;
      logic [4:0]  a, r1, r2;
      logic [31:0] d;
      r  = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 3) != 0);
      a  = 5'($urandom);
      d  = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
      applyStimulus(r, we, a, d, r1, r2);
      #2;
      checkOutput("rand_rd1", rd1, exp_read(ra1));
      checkOutput("rand_rd2", rd2, exp_read(ra2));
      checkOutput("rand_count", {16'h0, wr_count}, 32'(ref_cnt));
      step();
    end

    // Fill 1..31 with their index, then reset together with a write to 31.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      checkOutput("fill_rd1", rd1, 32'(i));
    end
    applyStimulus(1'b1, 1'b1, 5'd31, 32'd31, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(i);
      #1;
      checkOutput("midreset_rd1", rd1, 32'h0);
      checkOutput("midreset_rd2", rd2, 32'h0);
    end
    checkOutput("midreset_count", {16'h0, wr_count}, 32'h0);

    // Counter wrap: 65535 committed writes, then one more.
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1'b0, 1'b1, 5'((i % 31) + 1), 32'(i), 5'd0, 5'd0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    #1;
    checkOutput("wrap_before", {16'h0, wr_count}, 32'h0000FFFF);
    checkOutput("wrap_data", rd1, ref_mem[7]);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'hCAFEF00D, 5'd0, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
    #1;
    checkOutput("wrap_after", {16'h0, wr_count}, 32'h0);
    checkOutput("wrap_last_rd1", rd1, 32'hCAFEF00D);
    checkOutput("wrap_last_rd2", rd2, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Register file for the five-stage MIPS datapath. It consumes the 5-bit write-register address selected by `mux_5` (rt vs rd) after that address passes through the MEM/WB latch. It also supplies the two source operands read in ID. The block holds 32 general-purpose 32-bit registers with two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, default 32, width of each register and data port.
- `ADDR_W`, default 5, register address width; the depth is 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `regwrite`  in  1  write enable from WB control.
- `wa`  in  ADDR_W  write address (the `mux_5` output, latched through MEM/WB).
- `wd`  in  DATA_W  write data.
- `ra1`  in  ADDR_W  read address, port 1 (rs).
- `ra2`  in  ADDR_W  read address, port 2 (rt).
- `rd1`  out  DATA_W  read data, port 1.
- `rd2`  out  DATA_W  read data, port 2.
- `wr_count`  out  16  count of committed writes; diagnostic output.

## Operation
- Storage: 2^ADDR_W registers of DATA_W bits.
- Write: on a rising edge of `clk` with `rst`=0, `regwrite`=1 and `wa`≠0, the entry `mem[wa]` takes `wd`.
  - A write with `wa`=0 is discarded; entry 0 always reads 0.
- Committed-write counter:
  - `wr_count` increments by 1 for every committed write only.
  - A write to `wa`=0 is not committed and does not increment it.
  - It wraps from 0xFFFF to 0x0000 with no flag.
- Reads are combinational:
  - `rd1` = `mem[ra1]` and `rd2` = `mem[ra2]`.
  - Any read of address 0 returns 0.
- Both read ports may address the same register; both return the same value.
- X or Z on `regwrite` is treated as no write. The bench checks that no entry changes.
- Reset:
  - On a rising edge with `rst`=1, all entries and `wr_count` clear to 0.
  - Reset overrides a simultaneous write.
  - Reset asserted mid-program loses all register contents. This is intended.

## Timing
- Write latency: `wd` is visible at `rd1`/`rd2` in the cycle after the write edge. Exception: the bypass feature under Configuration.
- Read latency: zero cycles. The read outputs settle combinationally from `ra1`/`ra2` and the storage.
- Reset values:
  - `rd1`=0, `rd2`=0 after reset for any address.
  - `wr_count`=0.
- Same-cycle read and write to the same nonzero address with the macro undefined: the read returns the old value. The new value appears after the edge.
- There is no handshake. A write completes unconditionally in its cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If `regwrite`=1, `wa`≠0 and `ra1`==`wa`, then `rd1`=`wd` in the same cycle. The same rule applies to `ra2`/`rd2`.
  - This lets WB and ID share one cycle without a separate forwarding path.
- `REGFILE_BYPASS_EN` undefined:
  - The read ports return stored contents only.
  - The hazard unit must stall one extra cycle on a WB/ID address match.

## Structure
- Shared package `mips_pkg`:
  - `REG_ADDR_W`=5, `DATA_W`=32, `NUM_REGS`=32.
  - `REG_ZERO`=5'd0.
  - typedef `reg_addr_t` (5-bit).
  - typedef `word_t` (32-bit).
- Sub-module `mux_32`: 2:1 32-bit bypass select, one instance per read port, instantiated only under `REGFILE_BYPASS_EN`.
- Storage is a plain array inside `register_file`; there is no further hierarchy.

## Test plan
- Reset then read: assert `rst` one cycle, then read all 32 addresses -> `rd1`=`rd2`=0 everywhere, `wr_count`=0.
- Write/read: `regwrite`=1, `wa`=5'b01010, `wd`=32'hDEADBEEF. Next cycle set `ra1`=5'b01010 -> `rd1`=32'hDEADBEEF, `wr_count`=1.
- Register zero: write 32'hFFFFFFFF to `wa`=0 -> `rd1`=0 with `ra1`=0, `wr_count` unchanged.
- Same-cycle hazard: `wa`=`ra2`=5'b10101, old value 32'h1, `wd`=32'h2 -> `rd2`=32'h1 before the edge (bypass undefined) or 32'h2 (bypass defined); 32'h2 after the edge in both builds.
- Reset mid-operation: fill registers 1–31 with their index value, then assert `rst` together with `regwrite`=1, `wa`=5'b11111 -> all entries 0, `wr_count`=0, register 31 not written.
- Counter wrap: preload 65535 committed writes, then do one more -> `wr_count`=0x0000.
